pe_mac_stream: RTL and testbench
================================

// Module: pe_mac_stream
// PURPOSE
//  Streaming multi-lane signed dot-product PE: computes y = sum(a[i]*b[i]) for i = 0..len-1.
//  Consumes LANES element pairs per beat over a valid/ready stream instead of full-vector ports.
//  Vector length is runtime-programmable, with optional output saturation.
//  Sits in the matrix-vector datapath, one instance per output row; its result feeds the row collector.
// PARAMETERS
//  DW     16   signed element width of a and b
//  LANES  4    element pairs consumed per beat (>=1)
//  N_MAX  786  maximum vector length; len port width LW = $clog2(N_MAX+1)
//  OUT_W  32   width of result y
//  SAT    1    1: saturate y to OUT_W signed range; 0: wrap (keep low OUT_W bits)
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous reset, active-low
//  clear      in   1            synchronous abort; returns to IDLE and discards the partial sum
//  start      in   1            begin a dot product; sampled only in IDLE
//  len        in   LW           vector length, sampled with start; range 0..N_MAX
//  busy       out  1            high in any state other than IDLE
//  in_valid   in   1            a_data/b_data beat valid
//  in_ready   out  1            PE accepts a beat this cycle
//  a_data     in   LANES*DW     lane k = bits [k*DW +: DW], signed; element index = beat*LANES+k
//  b_data     in   LANES*DW     same layout as a_data
//  out_valid  out  1            y/ovf valid; held until out_ready
//  out_ready  in   1            downstream accepts y
//  y          out  OUT_W        signed dot-product result
//  ovf        out  1            full-precision sum exceeded the OUT_W signed range (SAT=1 or 0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; busy=0, in_ready=0, out_valid=0, y=0, ovf=0; acc, pipeline regs and counters = 0.
//  - States:
//    - IDLE -> ACCUM on start with len>0.
//    - IDLE -> DRAIN on start with len==0; result 0.
//    - ACCUM -> DRAIN when the last beat is accepted.
//    - DRAIN (1 cycle) -> OUT.
//    - OUT -> IDLE on out_valid&&out_ready.
//    - start outside IDLE is ignored.
//  - On start: latch rem = len and clear acc.
//    - A beat is accepted when in_valid && in_ready.
//    - in_ready = (state==ACCUM).
//    - Each accepted beat does rem -= min(rem, LANES).
//    - The last beat is the one with rem <= LANES.
//  - Tail masking: on the last beat, lanes k >= rem contribute 0 regardless of data (len not a multiple of LANES).
//  - Datapath, stage 1:
//    - LANES signed DW x DW products, summed by an adder tree.
//    - Registered into psum_q, with psum_v = beat accepted.
//    - psum width PW = 2*DW + $clog2(LANES).
//  - Datapath, stage 2: if psum_v, then acc <= acc + sext(psum_q).
//    - acc width AW = 2*DW + $clog2(N_MAX) + 1; acc never overflows.
//  - Latency:
//    - Last beat accepted at cycle T -> out_valid=1 at T+2.
//    - len==0: start at T -> out_valid at T+2.
//  - Result at OUT entry:
//    - ovf = acc outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    - y = SAT ? clamp(acc) : acc[OUT_W-1:0].
//    - y and ovf are held stable while out_valid && !out_ready.
//  - Back-to-back: start may be asserted in the cycle after the OUT handshake (IDLE); no combinational start->in_ready path.
//  - clear: highest priority after reset; in any state -> IDLE next cycle.
//    - out_valid=0, psum_v=0, acc=0.
//    - A beat presented in the same cycle is not accepted (in_ready forced 0).
//  - in_valid while not in ACCUM: ignored, no side effects.
//  - Mid-operation rst_n assertion: identical to power-on reset.
// STRUCTURE
//  - pe_pkg: state enum pe_state_t {IDLE, ACCUM, DRAIN, OUT}.
//  - pe_pkg: width functions psum_w(DW,LANES), acc_w(DW,N_MAX).
//  - pe_pkg: sat_clamp function (AW -> OUT_W).
//  - Sub-module pe_lane_tree #(DW,LANES): combinational masked multiply + adder tree -> PW-bit sum.
//  - Top: FSM, rem counter, psum_q/acc registers, output register.
// TESTING
//  1. DW=16, LANES=4, len=8, a=1..8, b=all 2, in_valid held high -> 2 beats accepted, y=72, ovf=0, out_valid 2 cycles after 2nd beat.
//  2. len=5, lanes 1..3 of 2nd beat = 0x7FFF garbage, a=b=1 elsewhere -> y=5 (tail masked).
//  3. len=0 start -> in_ready never high, out_valid at T+2, y=0.
//  4. OUT_W=16, SAT=1, len=4, a=b=0x7FFF -> ovf=1, y=0x7FFF; same with SAT=0 -> y=low 16 bits of 4*0x3FFF0001 = 0x0004, ovf=1.
//  5. Random in_valid gaps and out_ready held low 5 cycles -> y stable, beat count exact, results match golden model.
//  6. clear mid-ACCUM, and rst_n low mid-ACCUM -> IDLE, outputs at reset values; following len=4, a=b=-1 -> y=4.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared state type, width helpers and output clamping for the streaming dot-product PE
package pe_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} pe_state_t;

  // Working width used when comparing an accumulator against an output range
  localparam int CLAMP_W = 64;

  // Width of one beat's lane sum: full product width plus growth of the adder tree
  function automatic int psum_w(input int dw, input int lanes);
    return 2 * dw + $clog2(lanes);
  endfunction

  // Accumulator width sized so the longest vector of extreme values cannot overflow
  function automatic int acc_w(input int dw, input int n_max);
    return 2 * dw + $clog2(n_max) + 1;
  endfunction

  // True when v does not fit in an out_w-bit signed integer
  function automatic logic sat_ovf(input logic signed [CLAMP_W-1:0] v, input int out_w);
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) || (v < lo);
  endfunction

  // Clamp v into the out_w-bit signed range; caller keeps the low out_w bits
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(input logic signed [CLAMP_W-1:0] v,
                                                          input int out_w);
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_lane_tree.sv
// pe_lane_tree: per-lane signed multipliers with lane masking, reduced by a binary adder tree
module pe_lane_tree
  import pe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 4,
  localparam int PW   = psum_w(DW, LANES)
) (
  input  logic [LANES*DW-1:0]  a_data,
  input  logic [LANES*DW-1:0]  b_data,
  input  logic [LANES-1:0]     lane_en,
  output logic signed [PW-1:0] sum
);

  logic signed [2*DW-1:0] prod [LANES];
  logic signed [PW-1:0]   node [2*LANES-1];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DW-1:0] a_k;
    logic signed [DW-1:0] b_k;
    assign a_k     = a_data[k*DW +: DW];
    assign b_k     = b_data[k*DW +: DW];
    assign prod[k] = a_k * b_k;
  end

  // Heap-ordered tree: leaves hold masked products, each inner node adds its two children
  always_comb begin
    for (int n = 0; n < 2 * LANES - 1; n++) begin
      node[n] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      node[LANES-1+k] = lane_en[k] ? PW'(prod[k]) : '0;
    end
    for (int i = LANES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
  end

  assign sum = node[0];

endmodule

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: streaming multi-lane signed dot-product engine with optional output saturation
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int N_MAX = 786,
  parameter int OUT_W = 32,
  parameter int SAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         start,
  input  logic [$clog2(N_MAX+1)-1:0]   len,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DW-1:0]          a_data,
  input  logic [LANES*DW-1:0]          b_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             y,
  output logic                         ovf
);

  localparam int LW = $clog2(N_MAX + 1);
  localparam int PW = psum_w(DW, LANES);
  localparam int AW = acc_w(DW, N_MAX);
  localparam logic [LW-1:0] LANES_LW = LW'(LANES);

  pe_state_t             state_q, state_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic signed [PW-1:0]  psum_q, psum_d;
  logic                  psum_v_q, psum_v_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]      y_q, y_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [LANES-1:0]            lane_en;
  logic signed [PW-1:0]        lane_sum;
  logic signed [AW-1:0]        acc_sum;
  logic signed [CLAMP_W-1:0]   acc_ext;
  logic signed [CLAMP_W-1:0]   clamp_val;
  logic                        ovf_val;
  logic                        accept;
  logic                        last_beat;

  assign in_ready  = in_ready_q & ~clear;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

  assign accept    = in_valid & in_ready;
  assign last_beat = (rem_q <= LANES_LW);

  // Only lanes still holding live elements contribute, which zeroes the tail of a short final beat
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_en[k] = (32'(rem_q) > 32'(k));
    end
  end

  pe_lane_tree #(
    .DW    (DW),
    .LANES (LANES)
  ) u_lane_tree (
    .a_data  (a_data),
    .b_data  (b_data),
    .lane_en (lane_en),
    .sum     (lane_sum)
  );

  assign acc_sum   = psum_v_q ? (acc_q + AW'(psum_q)) : acc_q;
  assign acc_ext   = CLAMP_W'(acc_sum);
  assign clamp_val = sat_clamp(acc_ext, OUT_W);
  assign ovf_val   = sat_ovf(acc_ext, OUT_W);

  // Next-state, remaining-count and datapath updates; clear overrides all of it
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    psum_d   = psum_q;
    psum_v_d = 1'b0;
    acc_d    = acc_sum;
    y_d      = y_q;
    ovf_d    = ovf_q;

    if (accept) begin
      psum_d   = lane_sum;
      psum_v_d = 1'b1;
      rem_d    = last_beat ? '0 : (rem_q - LANES_LW);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = len;
          acc_d   = '0;
          state_d = (len == '0) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUT;
        y_d     = (SAT != 0) ? clamp_val[OUT_W-1:0] : acc_ext[OUT_W-1:0];
        ovf_d   = ovf_val;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d  = IDLE;
      rem_d    = '0;
      psum_v_d = 1'b0;
      acc_d    = '0;
      y_d      = '0;
      ovf_d    = 1'b0;
    end

    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == OUT);
  end

  // State, datapath and registered outputs with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      psum_q      <= '0;
      psum_v_q    <= 1'b0;
      acc_q       <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      psum_q      <= psum_d;
      psum_v_q    <= psum_v_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// tb_pe_mac_stream: scoreboard bench driving three PE builds (32-bit, 16-bit saturating, 16-bit wrapping)
module tb_pe_mac_stream;

  localparam int DW     = 16;
  localparam int LANES  = 4;
  localparam int N_MAX  = 786;
  localparam int LW     = $clog2(N_MAX + 1);
  localparam int VEC_SZ = N_MAX + LANES;

  typedef struct {
    logic [31:0] y32;
    logic        ovf32;
    logic [15:0] y16s;
    logic        ovf16s;
    logic [15:0] y16w;
    logic        ovf16w;
    int          beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, clear, start, in_valid, out_ready;
  logic [LW-1:0] len;
  logic [LANES*DW-1:0] a_data, b_data;

  logic busy, in_ready, out_valid, ovf;
  logic [31:0] y;
  logic busy_s, in_ready_s, out_valid_s, ovf_s;
  logic [15:0] y_s;
  logic busy_w, in_ready_w, out_valid_w, ovf_w;
  logic [15:0] y_w;

  logic signed [DW-1:0] vec_a [VEC_SZ];
  logic signed [DW-1:0] vec_b [VEC_SZ];

  exp_t   exp_q [$];
  int     vectors = 0;
  int     miscompares = 0;
  int     pushed = 0;
  int     popped = 0;
  int     beat_cnt = 0;
  int     stall_len = 0;
  int     stall_left = 0;
  longint cyc = 0;
  longint last_evt = 0;
  logic   prev_ov = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pe_mac_stream #(.DW(DW), .LANES(LANES), .N_MAX(N_MAX), .OUT_W(32), .SAT(1)) dut_main (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf));

  pe_mac_stream #(.DW(DW), .LANES(LANES), .N_MAX(N_MAX), .OUT_W(16), .SAT(1)) dut_sat16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .len(len), .busy(busy_s),
    .in_valid(in_valid), .in_ready(in_ready_s), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .ovf(ovf_s));

  pe_mac_stream #(.DW(DW), .LANES(LANES), .N_MAX(N_MAX), .OUT_W(16), .SAT(0)) dut_wrap16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .len(len), .busy(busy_w),
    .in_valid(in_valid), .in_ready(in_ready_w), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .y(y_w), .ovf(ovf_w));

  // One comparison: bump the counters and report any difference
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Saturate a signed value into a w-bit signed range
  function automatic longint sat_to(input longint s, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // Reference: plain dot product of the first n elements, then each output format derived from it
  function automatic exp_t refModel(input int n);
    exp_t        e;
    longint      s;
    logic [63:0] t;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s += longint'(vec_a[i]) * longint'(vec_b[i]);
    end
    t        = 64'(sat_to(s, 32));
    e.y32    = t[31:0];
    e.ovf32  = (sat_to(s, 32) != s);
    t        = 64'(sat_to(s, 16));
    e.y16s   = t[15:0];
    e.ovf16s = (sat_to(s, 16) != s);
    t        = 64'(s);
    e.y16w   = t[15:0];
    e.ovf16w = e.ovf16s;
    e.beats  = (n + LANES - 1) / LANES;
    return e;
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < VEC_SZ; i++) begin
      vec_a[i] = DW'($urandom);
      vec_b[i] = DW'($urandom);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 0);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 0);
    checkOutput({tag, "_y"}, 64'(y), 0);
    checkOutput({tag, "_ovf"}, 64'(ovf), 0);
  endtask

  // Issue one dot product; optionally abort it with clear (1) or reset (2) at beat abort_at
  task automatic applyStimulus(input int n, input int abort_kind, input int abort_at, input int gap_pct);
    int   nbeats;
    int   beat;
    int   guard;
    logic acc_now;
    nbeats = (n + LANES - 1) / LANES;
    if (abort_kind == 0) begin
      exp_q.push_back(refModel(n));
      pushed++;
    end
    start    = 1'b1;
    len      = LW'(n);
    in_valid = 1'b1;
    a_data   = {$urandom, $urandom};
    b_data   = {$urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    len   = LW'($urandom_range(0, N_MAX));
    beat  = 0;
    guard = 0;
    while (beat < nbeats && guard < 2000) begin
      for (int k = 0; k < LANES; k++) begin
        a_data[k*DW +: DW] = vec_a[beat*LANES+k];
        b_data[k*DW +: DW] = vec_b[beat*LANES+k];
      end
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      if (abort_kind != 0 && beat == abort_at) begin
        in_valid = 1'b1;
        break;
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) beat++;
      guard++;
    end
    if (abort_kind == 1) begin
      clear = 1'b1;
      @(negedge clk);
      checkOutput("clear_in_ready", 64'(in_ready), 0);
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkIdleOutputs("after_clear");
      @(posedge clk); #1;
    end else if (abort_kind == 2) begin
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("async_reset");
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkIdleOutputs("after_reset");
      @(posedge clk); #1;
    end else begin
      guard = 0;
      while (popped != pushed && guard < 3000) begin
        in_valid = 1'($urandom_range(0, 1));
        a_data   = {$urandom, $urandom};
        b_data   = {$urandom, $urandom};
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      if (guard >= 3000) checkOutput("result_timeout", 64'(popped), 64'(pushed));
    end
  endtask

  // Monitor: counts accepted beats and pops/compares the scoreboard whenever a result is presented
  initial begin : monitor
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        beat_cnt = 0;
      end else begin
        if (in_valid && in_ready) begin
          beat_cnt++;
          last_evt = cyc;
        end
        if (start && !busy && len == '0) last_evt = cyc;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_out_valid", 64'(out_valid), 0);
          end else begin
            cur = exp_q[0];
            if (!prev_ov) checkOutput("latency", 64'(cyc - last_evt), 2);
            checkOutput("y32", 64'(y), 64'(cur.y32));
            checkOutput("ovf32", 64'(ovf), 64'(cur.ovf32));
            checkOutput("y16_sat", 64'(y_s), 64'(cur.y16s));
            checkOutput("ovf16_sat", 64'(ovf_s), 64'(cur.ovf16s));
            checkOutput("y16_wrap", 64'(y_w), 64'(cur.y16w));
            checkOutput("ovf16_wrap", 64'(ovf_w), 64'(cur.ovf16w));
            if (out_ready) begin
              checkOutput("beat_count", 64'(beat_cnt), 64'(cur.beats));
              beat_cnt = 0;
              void'(exp_q.pop_front());
              popped++;
            end
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // Downstream model: holds out_ready low for stall_len cycles of each presented result
  initial begin : ready_driver
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!out_valid) begin
        out_ready  = 1'b0;
        stall_left = stall_len;
      end else if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases followed by a randomized run
  initial begin : stimulus
    int n;
    rst_n    = 1'b0;
    clear    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    a_data   = '0;
    b_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("power_on_reset");
    checkOutput("reset_y16_sat", 64'(y_s), 0);
    checkOutput("reset_y16_wrap", 64'(y_w), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] len=8 ramp times 2");
    fillRandom();
    for (int i = 0; i < 8; i++) begin
      vec_a[i] = DW'(i + 1);
      vec_b[i] = 16'sd2;
    end
    applyStimulus(8, 0, 0, 0);

    $display("[TB] len=5 with garbage tail lanes");
    for (int i = 0; i < 8; i++) begin
      vec_a[i] = (i < 5) ? 16'sd1 : 16'sh7FFF;
      vec_b[i] = (i < 5) ? 16'sd1 : 16'sh7FFF;
    end
    applyStimulus(5, 0, 0, 0);

    $display("[TB] len=0");
    applyStimulus(0, 0, 0, 0);

    $display("[TB] len=4 max positive values, saturation and wrap");
    for (int i = 0; i < 4; i++) begin
      vec_a[i] = 16'sh7FFF;
      vec_b[i] = 16'sh7FFF;
    end
    stall_len = 5;
    applyStimulus(4, 0, 0, 0);

    $display("[TB] full-length most-negative vectors");
    for (int i = 0; i < VEC_SZ; i++) begin
      vec_a[i] = -16'sd32768;
      vec_b[i] = -16'sd32768;
    end
    stall_len = 1;
    applyStimulus(N_MAX, 0, 0, 10);

    $display("[TB] randomized lengths, gaps and stalls");
    for (int t = 0; t < 30; t++) begin
      fillRandom();
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 60));
      stall_len = (t % 6 == 0) ? 5 : int'($urandom_range(0, 5));
      applyStimulus(n, 0, 0, int'($urandom_range(0, 60)));
    end

    $display("[TB] clear and reset in the middle of accumulation");
    fillRandom();
    stall_len = 0;
    applyStimulus(40, 1, 3, 20);
    applyStimulus(40, 2, 5, 20);
    applyStimulus(12, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vec_a[i] = -16'sd1;
      vec_b[i] = -16'sd1;
    end
    applyStimulus(4, 0, 0, 0);

    repeat (4) @(posedge clk);
    checkOutput("leftover_expected", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
